// File: rtl/gpmc_sram_burst.sv
`timescale 1ns / 1ps
// On-FPGA 16-bit SRAM slave for the AM335x GPMC (sync, A/D multiplexed) with bursts,
// programmable read latency and WAIT. Define GPMC_BURST_WRAP_EN for burst-aligned address wrap.
module gpmc_sram_burst #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        GPMC_CLK,
  input  logic        GPMC_RST,
  inout  wire  [15:0] GPMC_AD,
  input  logic        GPMC_CS,
  input  logic        GPMC_ADV,
  input  logic        GPMC_DIR,
  input  logic        GPMC_OE,
  input  logic        GPMC_BE0,
  input  logic        GPMC_BE1,
  input  logic        GPMC_WP,
  output logic        GPMC_WAIT
);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA, DONE} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [2:0] LAT_LOAD  = 3'(RD_LAT - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, addr_inc;
  logic [4:0]        beat, beat_n;
  logic [2:0]        lat, lat_n;
  logic [1:0]        we;
  logic              rd_en;
  logic [15:0]       rdata;
  logic [15:0]       mem [0:(1 << ADDR_W) - 1];

`ifdef GPMC_BURST_WRAP_EN
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(BURST_LEN - 1);
  assign addr_inc = (addr & ~WRAP_MASK) | ((addr + ADDR_W'(1)) & WRAP_MASK);
`else
  assign addr_inc = addr + ADDR_W'(1);
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr;
    beat_n  = beat;
    lat_n   = lat;
    we      = '0;
    rd_en   = 1'b0;
    if (GPMC_CS) begin
      state_n = IDLE;
    end else if (!GPMC_ADV) begin
      // Address edge restarts from any state and never carries a data beat.
      addr_n = GPMC_AD[ADDR_W-1:0];
      beat_n = '0;
      if (GPMC_DIR) begin
        state_n = RD_WAIT;
        lat_n   = LAT_LOAD;
      end else begin
        state_n = WR_DATA;
      end
    end else begin
      unique case (state)
        WR_DATA: begin
          we     = {~GPMC_BE1, ~GPMC_BE0} & {2{~GPMC_WP}};
          addr_n = addr_inc;
          beat_n = beat + 5'd1;
          if (beat == LAST_BEAT) state_n = DONE;
        end
        RD_WAIT: begin
          if (lat == '0) begin
            state_n = RD_DATA;
            rd_en   = 1'b1;
            addr_n  = addr_inc;
          end else begin
            lat_n = lat - 3'd1;
          end
        end
        RD_DATA: begin
          // The beat counter tracks the word currently presented; the next word is fetched here.
          if (beat == LAST_BEAT) begin
            state_n = DONE;
          end else begin
            rd_en  = 1'b1;
            addr_n = addr_inc;
            beat_n = beat + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge GPMC_CLK or posedge GPMC_RST) begin
    if (GPMC_RST) begin
      state <= IDLE;
      addr  <= '0;
      beat  <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      beat  <= beat_n;
      lat   <= lat_n;
    end
  end

  always_ff @(posedge GPMC_CLK) begin
    if (we[0]) mem[addr][7:0]  <= GPMC_AD[7:0];
    if (we[1]) mem[addr][15:8] <= GPMC_AD[15:8];
    if (rd_en) rdata <= mem[addr];
  end

  assign GPMC_WAIT = (state == RD_WAIT);
  assign GPMC_AD   = (!GPMC_CS && !GPMC_OE && state == RD_DATA) ? rdata : 'z;

endmodule

// File: tb/tb_gpmc_sram_burst.sv
`timescale 1ns / 1ps
// Scoreboard bench for gpmc_sram_burst: stimulus queues timed expectations of {WAIT, AD},
// a negedge monitor compares them. Released AD reads back as 0xFFFF through pullups.
module tb_gpmc_sram_burst;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1, adv = 1'b1, dir = 1'b0, oe = 1'b0;
  logic        be0 = 1'b0, be1 = 1'b0, wp = 1'b0;
  logic        drv = 1'b0;
  logic [15:0] host_ad = '0;
  logic        wt;
  wire  [15:0] ad;

  assign ad = drv ? host_ad : 'z;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ad[i]);
  end

  gpmc_sram_burst #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT)) dut (
    .GPMC_CLK(clk), .GPMC_RST(rst), .GPMC_AD(ad), .GPMC_CS(cs), .GPMC_ADV(adv),
    .GPMC_DIR(dir), .GPMC_OE(oe), .GPMC_BE0(be0), .GPMC_BE1(be1), .GPMC_WP(wp),
    .GPMC_WAIT(wt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int          cyc;
    logic        w;
    logic [15:0] ad;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic push(input int c, input logic w, input logic [15:0] d, input string nm);
    exp_t e;
    e.cyc = c; e.w = w; e.ad = d; e.nm = nm;
    q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc == cyc && wt === e.w && ad === e.ad) passes++;
      else $display("FAIL %s (cyc %0d): got wait=%b ad=%h, required wait=%b ad=%h at cyc %0d",
                    e.nm, cyc, wt, ad, e.w, e.ad, e.cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [ADDR_W-1:0] a, input logic d);
    oe = 1'b1; cs = 1'b0; adv = 1'b0; dir = d;
    drv = 1'b1; host_ad = 16'(a);
    tick();
    adv = 1'b1;
  endtask

  task automatic wr_beat(input logic [15:0] d, input logic b1, input logic b0, input logic p);
    host_ad = d; be1 = b1; be0 = b0; wp = p;
    tick();
    be1 = 1'b0; be0 = 1'b0; wp = 1'b0;
  endtask

  task automatic wr_burst4(input logic [ADDR_W-1:0] a,
                           input logic [15:0] d0, d1, d2, d3);
    addr_phase(a, 1'b0);
    wr_beat(d0, 1'b0, 1'b0, 1'b0);
    wr_beat(d1, 1'b0, 1'b0, 1'b0);
    wr_beat(d2, 1'b0, 1'b0, 1'b0);
    wr_beat(d3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cs = 1'b1; adv = 1'b1; drv = 1'b0; oe = 1'b1;
    tick();
  endtask

  // Checks WAIT for RD_LAT cycles, then nb beats; a full burst also checks bus release.
  task automatic read_burst(input logic [ADDR_W-1:0] a,
                            input logic [15:0] w0, w1, w2, w3,
                            input int nb, input string nm);
    logic [15:0] w[4];
    int e0, last;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    addr_phase(a, 1'b1);
    e0 = cyc;
    drv = 1'b0; oe = 1'b0;
    for (int i = 0; i < int'(RD_LAT); i++) push(e0 + i, 1'b1, 16'hFFFF, {nm, " wait"});
    for (int k = 0; k < nb; k++) push(e0 + int'(RD_LAT) + k, 1'b0, w[k], {nm, " beat"});
    last = e0 + int'(RD_LAT) + nb - 1;
    if (nb == int'(BURST_LEN)) begin
      push(last + 1, 1'b0, 16'hFFFF, {nm, " release"});
      last++;
    end
    while (cyc < last) tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int e0;
    repeat (3) tick();
    push(cyc, 1'b0, 16'hFFFF, "reset state");
    @(negedge clk);
    #1;
    checks++;
    if (wt === 1'b0 && ad === 16'hFFFF) passes++;
    else $display("FAIL in-reset direct: got wait=%b ad=%h", wt, ad);
    rst = 1'b0;
    tick();

    wr_burst4(10'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    read_burst(10'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4, "burst 0x010");
    idle();

    addr_phase(10'h020, 1'b0);
    wr_beat(16'hFFFF, 1'b0, 1'b0, 1'b0);
    idle();
    addr_phase(10'h020, 1'b0);
    wr_beat(16'hABCD, 1'b1, 1'b0, 1'b0);
    read_burst(10'h020, 16'hFFCD, '0, '0, '0, 1, "byte lane");
    idle();
    addr_phase(10'h020, 1'b0);
    wr_beat(16'h0000, 1'b0, 1'b0, 1'b1);
    read_burst(10'h020, 16'hFFCD, '0, '0, '0, 1, "write protect");
    idle();

    wr_burst4(10'h3FC, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    wr_burst4(10'h000, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    wr_burst4(10'h3FE, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    idle();
`ifdef GPMC_BURST_WRAP_EN
    read_burst(10'h3FC, 16'hA003, 16'hA004, 16'hA001, 16'hA002, 4, "wrap 0x3FC");
    idle();
    read_burst(10'h000, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4, "wrap 0x000");
`else
    read_burst(10'h3FC, 16'h5555, 16'h6666, 16'hA001, 16'hA002, 4, "linear 0x3FC");
    idle();
    read_burst(10'h000, 16'hA003, 16'hA004, 16'hBBBB, 16'hCCCC, 4, "linear 0x000");
`endif
    idle();

    read_burst(10'h010, 16'h1111, 16'h2222, '0, '0, 2, "cs abort");
    tick();
    cs = 1'b1;
    push(cyc, 1'b0, 16'hFFFF, "cs comb release");
    @(negedge clk);
    #1;
    tick();
    read_burst(10'h010, 16'h1111, '0, '0, '0, 1, "fresh after cs");
    idle();

    wr_burst4(10'h040, 16'h4040, 16'h4141, 16'h4242, 16'h4343);
    idle();
    read_burst(10'h010, 16'h1111, 16'h2222, 16'h3333, '0, 3, "pre-restart");
    read_burst(10'h040, 16'h4040, 16'h4141, 16'h4242, 16'h4343, 4, "restart 0x040");
    idle();

    addr_phase(10'h054, 1'b0);
    wr_beat(16'h5454, 1'b0, 1'b0, 1'b0);
    idle();
    wr_burst4(10'h050, 16'h5050, 16'h5151, 16'h5252, 16'h5353);
    wr_beat(16'hDEAD, 1'b0, 1'b0, 1'b0);
    idle();
    read_burst(10'h050, 16'h5050, 16'h5151, 16'h5252, 16'h5353, 4, "burst 0x050");
    idle();
    read_burst(10'h054, 16'h5454, '0, '0, '0, 1, "5th beat ignored");
    idle();

    addr_phase(10'h010, 1'b1);
    e0 = cyc;
    drv = 1'b0; oe = 1'b0;
    push(e0, 1'b1, 16'hFFFF, "pre-reset wait");
    @(negedge clk);
    #1;
    checks++;
    if (wt === 1'b1) passes++;
    else $display("FAIL pre-reset wait direct: got wait=%b", wt);
    rst = 1'b1;
    #1;
    checks++;
    if (wt === 1'b0 && ad === 16'hFFFF) passes++;
    else $display("FAIL async reset direct: got wait=%b ad=%h", wt, ad);
    push(e0 + 1, 1'b0, 16'hFFFF, "mid-read reset");
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    push(e0 + 2, 1'b0, 16'hFFFF, "idle after reset");
    tick();
    @(negedge clk);
    #1;
    read_burst(10'h010, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4, "preserved after reset");
    idle();

    repeat (20) if (q.size() > 0) tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      $display("FAIL %s: never sampled, required wait=%b ad=%h at cyc %0d", e.nm, e.w, e.ad, e.cyc);
    end
    if (passes != checks || checks < 12) $display("FAIL summary: %0d of %0d", passes, checks);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
